// File: rtl/mux_nway_pipe_if.sv
// rtl/mux_nway_pipe_if.sv - handshake/bus bundle for the mux_nway_pipe stage
//
// Purpose: groups the upstream (in_*), downstream (out_*) and control signals
// of one mux_nway_pipe stage so they travel as a single port.
// Signals:
//   in_bus      INPUTS*LENGTH packed inputs, input k = in_bus[k*LENGTH +: LENGTH]
//   sel         SEL_W        input select, sampled with in_valid
//   in_valid    1            upstream presents in_bus/sel
//   in_ready    1            stage can accept this cycle
//   flush       1            synchronous flush, drops all held entries
//   out         LENGTH       registered selected data
//   out_sel_err 1            sel of the entry on out was >= INPUTS
//   out_valid   1            out holds a valid entry
//   out_ready   1            downstream accepts out this cycle
//   occupancy   2            number of held entries (0..2)
// Modports: slave = the stage itself, master = the environment driving it.
interface mux_nway_pipe_if #(
  parameter int LENGTH = 16,
  parameter int INPUTS = 4
);
  localparam int SEL_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;

  logic [INPUTS*LENGTH-1:0] in_bus;
  logic [SEL_W-1:0]         sel;
  logic                     in_valid;
  logic                     in_ready;
  logic                     flush;
  logic [LENGTH-1:0]        out;
  logic                     out_sel_err;
  logic                     out_valid;
  logic                     out_ready;
  logic [1:0]               occupancy;

  modport slave (
    input  in_bus, sel, in_valid, flush, out_ready,
    output in_ready, out, out_sel_err, out_valid, occupancy
  );

  modport master (
    output in_bus, sel, in_valid, flush, out_ready,
    input  in_ready, out, out_sel_err, out_valid, occupancy
  );
endinterface

// File: rtl/mux_nway_pipe.sv
// rtl/mux_nway_pipe.sv - N-input registered mux stage with valid/ready and 2-entry skid
//
// Purpose: selects one of INPUTS operands of LENGTH bits and carries it across
// a pipeline stage boundary. The selected word is captured into a main
// register (drives out) or, when downstream stalls, into a skid register, so
// in_ready never depends combinationally on out_ready.
// Ports:
//   clk  clock, all state updates on the rising edge
//   rst  synchronous active-high reset
//   bus  mux_nway_pipe_if.slave (in_bus, sel, in_valid, in_ready, flush,
//        out, out_sel_err, out_valid, out_ready, occupancy)
module mux_nway_pipe #(
  parameter int LENGTH = 16,
  parameter int INPUTS = 4
) (
  input  logic            clk,
  input  logic            rst,
  mux_nway_pipe_if.slave  bus
);
  localparam int SEL_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;
  localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W+1)'(INPUTS);

  // State is encoded directly as {skid_valid, main_valid}; the skid only
  // ever holds an entry while main does, so 2'b10 is unreachable.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic              main_valid;
  logic [LENGTH-1:0] main_data;
  logic              main_err;
  logic              skid_valid;
  logic [LENGTH-1:0] skid_data;
  logic              skid_err;

  logic [LENGTH-1:0] sel_data;
  logic              sel_err;
  logic              accept;
  logic [1:0]        state;

  assign state = {skid_valid, main_valid};

  // Out-of-range selects fall back to the last input and are flagged.
  always_comb begin
    sel_data = bus.in_bus[(INPUTS-1)*LENGTH +: LENGTH];
    sel_err  = ({1'b0, bus.sel} >= SEL_LIMIT);
    for (int k = 0; k < INPUTS; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        sel_data = bus.in_bus[k*LENGTH +: LENGTH];
      end
    end
  end

  // Ready depends only on registered state and rst.
  assign bus.in_ready = !skid_valid && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_err   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_valid <= 1'b1;
            main_data  <= sel_data;
            main_err   <= sel_err;
          end
        end
        ST_ONE: begin
          if (accept && bus.out_ready) begin
            main_data <= sel_data;
            main_err  <= sel_err;
          end else if (accept) begin
            // Downstream stalled: park the new entry behind main.
            skid_valid <= 1'b1;
            skid_data  <= sel_data;
            skid_err   <= sel_err;
          end else if (bus.out_ready) begin
            main_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (bus.out_ready) begin
            main_data  <= skid_data;
            main_err   <= skid_err;
            skid_valid <= 1'b0;
          end
        end
        default: begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out         = main_data;
  assign bus.out_sel_err = main_err;
  assign bus.out_valid   = main_valid;
  assign bus.occupancy   = (state == ST_FULL) ? 2'd2 :
                           (state == ST_ONE)  ? 2'd1 : 2'd0;
endmodule

// File: tb/tb_mux_nway_pipe.sv
// tb/tb_mux_nway_pipe.sv - self-checking bench for mux_nway_pipe
module tb_mux_nway_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_nway_pipe_if #(.LENGTH(16), .INPUTS(4)) a_if();
  mux_nway_pipe_if #(.LENGTH(16), .INPUTS(3)) b_if();

  mux_nway_pipe #(.LENGTH(16), .INPUTS(4)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  mux_nway_pipe #(.LENGTH(16), .INPUTS(3)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] exp_out;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } sb_t;

  sb_t  sb[$];
  sb_t  cur_exp;
  int   checks = 0;
  int   passes = 0;
  logic        hold_prev = 1'b0;
  logic [15:0] prev_out;
  logic        prev_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and stability monitor for the INPUTS=4 instance.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_out", a_if.out, prev_out);
        chk("hold_err", a_if.out_sel_err, prev_err);
      end
      if (a_if.out_valid && a_if.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL sb_underflow: got out=%0h with no entry expected", a_if.out);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("sb_data", a_if.out, e.data);
          chk("sb_err", a_if.out_sel_err, e.err);
        end
      end
      if (a_if.flush) sb.delete();
      else if (a_if.in_valid && a_if.in_ready) sb.push_back(cur_exp);
      hold_prev = a_if.out_valid && !a_if.out_ready && !a_if.flush;
      prev_out  = a_if.out;
      prev_err  = a_if.out_sel_err;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic fill_full();
    next();
    a_if.out_ready = 1'b0;
    a_if.in_valid  = 1'b1;
    a_if.sel       = 2'd0;
    cur_exp        = '{16'h1111, 1'b0};
    next();
    a_if.sel       = 2'd3;
    cur_exp        = '{16'h4444, 1'b0};
    next();
  endtask

  initial begin
    vec_t stream_a[4];
    vec_t stream_b[4];
    stream_a[0] = '{2'd0, 16'h1111, 1'b0};
    stream_a[1] = '{2'd1, 16'h2222, 1'b0};
    stream_a[2] = '{2'd2, 16'h3333, 1'b0};
    stream_a[3] = '{2'd3, 16'h4444, 1'b0};
    stream_b[0] = '{2'd3, 16'h3333, 1'b1};
    stream_b[1] = '{2'd0, 16'h1111, 1'b0};
    stream_b[2] = '{2'd2, 16'h3333, 1'b0};
    stream_b[3] = '{2'd1, 16'h2222, 1'b0};

    a_if.in_bus = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    a_if.sel = '0; a_if.in_valid = 1'b0; a_if.flush = 1'b0; a_if.out_ready = 1'b0;
    b_if.in_bus = {16'h3333, 16'h2222, 16'h1111};
    b_if.sel = '0; b_if.in_valid = 1'b0; b_if.flush = 1'b0; b_if.out_ready = 1'b0;
    cur_exp = '0;

    // Reset then idle.
    rst = 1'b1;
    repeat (2) next();
    @(negedge clk);
    chk("rst_in_ready_a", a_if.in_ready, 0);
    chk("rst_in_ready_b", b_if.in_ready, 0);
    next();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", a_if.in_ready, 1);
    chk("post_rst_out", a_if.out, 16'h0000);
    chk("post_rst_out_valid", a_if.out_valid, 0);
    chk("post_rst_occ", a_if.occupancy, 0);

    // Back-to-back stream, one entry per cycle, one-cycle latency.
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next();
      a_if.sel = stream_a[i].sel;
      a_if.in_valid = 1'b1;
      cur_exp = '{stream_a[i].exp_out, stream_a[i].exp_err};
      @(negedge clk);
      chk("stream_in_ready", a_if.in_ready, 1);
      if (i > 0) begin
        chk("stream_out", a_if.out, stream_a[i-1].exp_out);
        chk("stream_out_valid", a_if.out_valid, 1);
      end
    end
    next();
    a_if.in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last", a_if.out, 16'h4444);
    next();
    @(negedge clk);
    chk("stream_drained", a_if.out_valid, 0);

    // Stall into the skid, then release in order.
    next();
    a_if.out_ready = 1'b0;
    a_if.in_valid = 1'b1;
    a_if.sel = 2'd1;
    cur_exp = '{16'h2222, 1'b0};
    next();
    a_if.sel = 2'd2;
    cur_exp = '{16'h3333, 1'b0};
    @(negedge clk);
    chk("skid_occ1", a_if.occupancy, 1);
    chk("skid_ready1", a_if.in_ready, 1);
    chk("skid_out1", a_if.out, 16'h2222);
    next();
    a_if.in_valid = 1'b0;
    @(negedge clk);
    chk("skid_occ2", a_if.occupancy, 2);
    chk("skid_ready2", a_if.in_ready, 0);
    chk("skid_out2", a_if.out, 16'h2222);
    next();
    a_if.out_ready = 1'b1;
    @(negedge clk);
    chk("skid_rel_out", a_if.out, 16'h2222);
    chk("skid_rel_ready", a_if.in_ready, 0);
    next();
    @(negedge clk);
    chk("skid_second_out", a_if.out, 16'h3333);
    chk("skid_ready_back", a_if.in_ready, 1);
    chk("skid_occ_after", a_if.occupancy, 1);
    next();
    @(negedge clk);
    chk("skid_empty", a_if.occupancy, 0);

    // Flush while FULL with in_valid high.
    fill_full();
    a_if.sel = 2'd2;
    cur_exp = '{16'h3333, 1'b0};
    a_if.flush = 1'b1;
    @(negedge clk);
    chk("flush_pre_occ", a_if.occupancy, 2);
    next();
    a_if.flush = 1'b0;
    a_if.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_occ", a_if.occupancy, 0);
    chk("flush_out_valid", a_if.out_valid, 0);
    chk("flush_out", a_if.out, 16'h0000);
    a_if.out_ready = 1'b1;
    next();
    next();
    @(negedge clk);
    chk("flush_no_ghost", a_if.out_valid, 0);

    // Flush in ONE with a same-cycle accept: the accept is dropped.
    a_if.out_ready = 1'b0;
    a_if.in_valid = 1'b1;
    a_if.sel = 2'd1;
    cur_exp = '{16'h2222, 1'b0};
    next();
    a_if.sel = 2'd2;
    cur_exp = '{16'h3333, 1'b0};
    a_if.flush = 1'b1;
    @(negedge clk);
    chk("flush1_ready", a_if.in_ready, 1);
    next();
    a_if.flush = 1'b0;
    a_if.in_valid = 1'b0;
    a_if.out_ready = 1'b1;
    @(negedge clk);
    chk("flush1_occ", a_if.occupancy, 0);
    chk("flush1_out_valid", a_if.out_valid, 0);

    // Reset while FULL with in_valid high.
    fill_full();
    a_if.sel = 2'd1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstfull_ready", a_if.in_ready, 0);
    next();
    rst = 1'b0;
    a_if.in_valid = 1'b0;
    @(negedge clk);
    chk("rstfull_out", a_if.out, 16'h0000);
    chk("rstfull_err", a_if.out_sel_err, 0);
    chk("rstfull_valid", a_if.out_valid, 0);
    chk("rstfull_occ", a_if.occupancy, 0);
    chk("rstfull_in_ready", a_if.in_ready, 1);
    a_if.out_ready = 1'b1;
    next();
    next();
    @(negedge clk);
    chk("rstfull_no_stale", a_if.out_valid, 0);

    // INPUTS=3 instance: out-of-range select and error flag per entry.
    b_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next();
      b_if.sel = stream_b[i].sel;
      b_if.in_valid = 1'b1;
      @(negedge clk);
      if (i > 0) begin
        chk("b_out", b_if.out, stream_b[i-1].exp_out);
        chk("b_err", b_if.out_sel_err, stream_b[i-1].exp_err);
      end
    end
    next();
    b_if.in_valid = 1'b0;
    @(negedge clk);
    chk("b_out_last", b_if.out, stream_b[3].exp_out);
    chk("b_err_last", b_if.out_sel_err, stream_b[3].exp_err);

    // Random traffic with random stalls, checked by the scoreboard.
    for (int c = 0; c < 300; c++) begin
      next();
      a_if.in_bus    = {$urandom, $urandom};
      a_if.sel       = 2'($urandom_range(0, 3));
      a_if.in_valid  = 1'($urandom_range(0, 1));
      a_if.out_ready = ($urandom_range(0, 3) != 0);
      cur_exp        = '{a_if.in_bus[int'(a_if.sel)*16 +: 16], 1'b0};
    end
    next();
    a_if.in_valid = 1'b0;
    a_if.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) next();
    @(negedge clk);
    chk("rand_drain_occ", a_if.occupancy, 0);
    chk("rand_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mux_nway_pipe.md
Name: mux_nway_pipe

Overview:
Parametrised N-input, LENGTH-bit pipeline mux stage with a registered output, valid/ready handshake and a 2-entry skid buffer. It is the sequential successor of the plain 2- and 3-input muxes, used in the pipeline wherever a selected operand must cross a stage boundary under stall/flush (forwarding, writeback select). Full-throughput streaming without a combinational path from out_ready to in_ready.

Parameters:
LENGTH, 16, data width of each input and of out
INPUTS, 4, number of data inputs (2..16)
SEL_W, $clog2(INPUTS) (min 1), width of sel; localparam, not overridable

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_bus  input  INPUTS*LENGTH  packed inputs; input k = in_bus[k*LENGTH +: LENGTH]
sel  input  SEL_W  input select, sampled with in_valid
in_valid  input  1  upstream presents in_bus/sel
in_ready  output  1  stage can accept this cycle
flush  input  1  synchronous pipeline flush, drops all held entries
out  output  LENGTH  registered selected data
out_sel_err  output  1  registered flag: sel of the entry on out was >= INPUTS
out_valid  output  1  out holds a valid entry
out_ready  input  1  downstream accepts out this cycle
occupancy  output  2  number of held entries (0, 1, 2)

Behaviour:
- Selection: sel < INPUTS picks input sel; sel >= INPUTS picks input INPUTS-1 and sets out_sel_err for that entry. Selection is combinational into the capture register only; out is always a register output.
- Accept = in_valid & in_ready. Transfer out = out_valid & out_ready.
- Storage: main reg (drives out/out_sel_err/out_valid) and skid reg. in_ready = !skid_valid & !rst, a function of registered state only.
- States: EMPTY (occ 0), ONE (main valid), FULL (main+skid valid).
  - EMPTY: accept -> ONE, main <= selected. Else stay.
  - ONE: accept & out_ready -> ONE, main <= new. Accept & !out_ready -> FULL, skid <= new. !accept & out_ready -> EMPTY. Neither -> hold.
  - FULL: in_ready=0. out_ready -> ONE, main <= skid. Else hold.
- Latency: entry accepted at edge t is visible on out after edge t (1 cycle); back-to-back accepts with out_ready=1 give 1 entry/cycle.
- Stability: while out_valid & !out_ready, out and out_sel_err do not change.
- Ordering: strictly FIFO; skid entry never overtakes main.
- Flush (priority below rst, above everything else): next state EMPTY, main/skid data cleared to 0, any same-cycle accept is dropped, and any same-cycle transfer still counts downstream (out_valid was 1 that cycle).
- Reset: out=0, out_sel_err=0, out_valid=0, occupancy=0, skid cleared; in_ready=0 while rst high, 1 on first cycle after. Reset mid-stream discards both entries.
- No arithmetic; data is not modified. INPUTS=2 with SEL_W=1 never raises out_sel_err.

Test Plan:
LENGTH=16, INPUTS=4, in_bus = {0x4444,0x3333,0x2222,0x1111} (input 0 = 0x1111), unless noted.
- Reset then idle -> out=0x0000, out_valid=0, occupancy=0, in_ready=1 from the first post-reset cycle.
- Stream sel=0,1,2,3 on 4 consecutive cycles, in_valid=1, out_ready=1 -> out = 0x1111,0x2222,0x3333,0x4444 on the 4 following cycles, in_ready stays 1.
- out_ready=0, push sel=1 then sel=2 -> occupancy 1 then 2, in_ready=0, out held at 0x2222. Raise out_ready -> 0x2222 then 0x3333 delivered in order, in_ready returns to 1 one cycle after the first transfer.
- INPUTS=3 build, sel=3 -> out=0x3333 (last input), out_sel_err=1. Next entry sel=0 -> out_sel_err=0.
- FULL state, assert flush with in_valid=1 -> next cycle occupancy=0, out_valid=0, out=0, flushed-cycle input not delivered.
- Assert rst while FULL and in_valid=1 -> in_ready=0 during reset, all outputs reset values next cycle, no stale entry appears afterward.
